// File: rtl/trap_ctrl.sv
// Trap-entry sequencer: arbitrates interrupts against WB-stage exceptions,
// resolves M/S delegation, pulses the trap target and hands a redirect PC to fetch.
module trap_ctrl #(
  parameter int XLEN  = 64,
  parameter int EXC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        priv,
  input  logic              mie,
  input  logic              sie,
  input  logic [11:0]       mip,
  input  logic [11:0]       mie_en,
  input  logic [11:0]       mideleg,
  input  logic [EXC_W-1:0]  medeleg,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   stvec,
  input  logic              exc_valid,
  input  logic [3:0]        exc_code,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [XLEN-1:0]   exc_tval,
  output logic              int_req,
  input  logic              hold_ack,
  input  logic [XLEN-1:0]   int_pc,
  output logic              trap_target_m,
  output logic              trap_target_s,
  output logic [XLEN-1:0]   cause,
  output logic [XLEN-1:0]   epc,
  output logic [XLEN-1:0]   tval,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_TRAP  = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic            r_is_int;
  logic [3:0]      r_code;
  logic            r_tgt_s;
  logic            r_int_req;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_epc;
  logic [XLEN-1:0] r_tval;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_priv_m;
  logic            w_priv_s;
  logic            w_priv_u;
  logic [11:0]     w_int_pend;
  logic [15:0]     w_pend16;
  logic [15:0]     w_ideleg16;
  logic [15:0]     w_edeleg16;
  logic            w_take_m;
  logic            w_take_s;
  logic            w_sel_valid;
  logic [3:0]      w_sel_code;
  logic            w_sel_deleg;
  logic            w_sel_take;
  logic            w_lat_take;
  logic            w_exc_tgt_s;
  logic            w_load_exc;
  logic            w_load_int;
  logic            w_trap_int;
  logic [XLEN-1:0] w_tvec;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_vec_off;
  logic [XLEN-1:0] w_redir_pc;

  assign w_priv_m   = (priv == 4'b1000);
  assign w_priv_s   = (priv == 4'b0010);
  assign w_priv_u   = (priv == 4'b0001);
  assign w_int_pend = mip & mie_en;

  // Zero-extend the per-code vectors to 16 entries so any 4-bit code indexes safely.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pad
      if (gi < 12) begin : g_int
        assign w_pend16[gi]   = w_int_pend[gi];
        assign w_ideleg16[gi] = mideleg[gi];
      end else begin : g_int_zero
        assign w_pend16[gi]   = 1'b0;
        assign w_ideleg16[gi] = 1'b0;
      end
      if (gi < EXC_W) begin : g_exc
        assign w_edeleg16[gi] = medeleg[gi];
      end else begin : g_exc_zero
        assign w_edeleg16[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_take_m = !w_priv_m || mie;
  assign w_take_s = w_priv_u || (w_priv_s && sie);

  // Fixed priority: MEI, MSI, MTI, SEI, SSI, STI.
  always_comb begin
    w_sel_valid = 1'b1;
    w_sel_code  = 4'd0;
    if (w_int_pend[11])      w_sel_code = 4'd11;
    else if (w_int_pend[3])  w_sel_code = 4'd3;
    else if (w_int_pend[7])  w_sel_code = 4'd7;
    else if (w_int_pend[9])  w_sel_code = 4'd9;
    else if (w_int_pend[1])  w_sel_code = 4'd1;
    else if (w_int_pend[5])  w_sel_code = 4'd5;
    else                     w_sel_valid = 1'b0;
  end

  assign w_sel_deleg = w_ideleg16[w_sel_code];
  assign w_sel_take  = w_sel_valid && (w_sel_deleg ? w_take_s : w_take_m);
  assign w_lat_take  = w_pend16[r_code] && (r_tgt_s ? w_take_s : w_take_m);
  assign w_exc_tgt_s = w_edeleg16[exc_code] && !w_priv_m;

  always_comb begin
    w_state_next = r_state;
    w_load_exc   = 1'b0;
    w_load_int   = 1'b0;
    w_trap_int   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (exc_valid) begin
          w_state_next = S_TRAP;
          w_load_exc   = 1'b1;
        end else if (w_sel_take) begin
          w_state_next = S_HOLD;
          w_load_int   = 1'b1;
        end
      end
      S_HOLD: begin
        if (exc_valid) begin
          w_state_next = S_TRAP;
          w_load_exc   = 1'b1;
        end else if (!w_lat_take) begin
          w_state_next = S_IDLE;
        end else if (hold_ack) begin
          w_state_next = S_TRAP;
          w_trap_int   = 1'b1;
        end
      end
      S_TRAP: begin
        w_state_next = S_REDIR;
      end
      S_REDIR: begin
        if (redirect_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign w_tvec     = r_tgt_s ? stvec : mtvec;
  assign w_base     = {w_tvec[XLEN-1:2], 2'b00};
  assign w_vec_off  = {{(XLEN-6){1'b0}}, r_code, 2'b00};
  assign w_redir_pc = (r_is_int && (w_tvec[1:0] == 2'b01)) ? (w_base + w_vec_off) : w_base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_is_int      <= 1'b0;
      r_code        <= 4'd0;
      r_tgt_s       <= 1'b0;
      r_int_req     <= 1'b0;
      r_cause       <= '0;
      r_epc         <= '0;
      r_tval        <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_load_exc) begin
        r_is_int <= 1'b0;
        r_code   <= exc_code;
        r_tgt_s  <= w_exc_tgt_s;
      end else if (w_load_int) begin
        r_is_int <= 1'b1;
        r_code   <= w_sel_code;
        r_tgt_s  <= w_sel_deleg;
      end

      // CSR write values change only on entry to TRAP and then persist.
      if (w_load_exc) begin
        r_cause <= {1'b0, {(XLEN-5){1'b0}}, exc_code};
        r_epc   <= exc_pc;
        r_tval  <= exc_tval;
      end else if (w_trap_int) begin
        r_cause <= {1'b1, {(XLEN-5){1'b0}}, r_code};
        r_epc   <= int_pc;
        r_tval  <= '0;
      end

      if (w_load_int) begin
        r_int_req <= 1'b1;
      end else if (w_state_next == S_IDLE) begin
        r_int_req <= 1'b0;
      end

      if (r_state == S_TRAP) begin
        r_redirect_pc <= w_redir_pc;
      end
    end
  end

  assign int_req        = r_int_req;
  assign trap_target_m  = (r_state == S_TRAP) && !r_tgt_s;
  assign trap_target_s  = (r_state == S_TRAP) && r_tgt_s;
  assign cause          = r_cause;
  assign epc            = r_epc;
  assign tval           = r_tval;
  assign redirect_valid = (r_state == S_REDIR);
  assign redirect_pc    = r_redirect_pc;
  assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected trap records are queued as stimulus is
// applied and checked against each trap pulse and the redirect that follows it.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  priv;
  logic        mie, sie;
  logic [11:0] mip, mie_en, mideleg;
  logic [15:0] medeleg;
  logic [63:0] mtvec, stvec;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [63:0] exc_pc, exc_tval;
  logic        int_req;
  logic        hold_ack;
  logic [63:0] int_pc;
  logic        trap_target_m, trap_target_s;
  logic [63:0] cause, epc, tval;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;

  trap_ctrl #(.XLEN(64), .EXC_W(16)) dut (
    .clk(clk), .rst(rst), .priv(priv), .mie(mie), .sie(sie),
    .mip(mip), .mie_en(mie_en), .mideleg(mideleg), .medeleg(medeleg),
    .mtvec(mtvec), .stvec(stvec),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .int_req(int_req), .hold_ack(hold_ack), .int_pc(int_pc),
    .trap_target_m(trap_target_m), .trap_target_s(trap_target_s),
    .cause(cause), .epc(epc), .tval(tval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tgt_s;
    logic [63:0] cause;
    logic [63:0] epc;
    logic [63:0] tval;
    logic [63:0] rpc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pm    = 0;
  int   n_ps    = 0;

  always @(negedge clk) begin
    if (trap_target_m) n_pm++;
    if (trap_target_s) n_ps++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic tgt_s, input logic [63:0] c, input logic [63:0] e,
                      input logic [63:0] t, input logic [63:0] r);
    exp_t x;
    x.tgt_s = tgt_s; x.cause = c; x.epc = e; x.tval = t; x.rpc = r;
    sb.push_back(x);
  endtask

  // Wait (bounded) for a trap pulse, pop the expected record and check it and the redirect.
  task automatic wait_trap(input string tag);
    int   n;
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(trap_target_m || trap_target_s) && n < 20);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.tgt_s = 1'b0; e.cause = '0; e.epc = '0; e.tval = '0; e.rpc = '0;
    end
    chk({tag, "_latency"}, 64'(n), 64'd1);
    chk({tag, "_tgt_m"}, 64'(trap_target_m), 64'(!e.tgt_s));
    chk({tag, "_tgt_s"}, 64'(trap_target_s), 64'(e.tgt_s));
    chk({tag, "_cause"}, cause, e.cause);
    chk({tag, "_epc"}, epc, e.epc);
    chk({tag, "_tval"}, tval, e.tval);
    tick();
    chk({tag, "_pulse_gone"}, 64'(trap_target_m | trap_target_s), 64'd0);
    chk({tag, "_rvalid"}, 64'(redirect_valid), 64'd1);
    chk({tag, "_rpc"}, redirect_pc, e.rpc);
    $display("[TB] trap %s: cause=%h epc=%h tval=%h rpc=%h", tag, cause, epc, tval, redirect_pc);
  endtask

  // Interrupt already pending and takeable: enter HOLD, ack at once, check the trap.
  task automatic run_int(input string tag, input logic [63:0] pc, input logic tgt_s,
                         input logic [3:0] code, input logic [63:0] rpc);
    push(tgt_s, {1'b1, 59'd0, code}, pc, 64'd0, rpc);
    tick();
    chk({tag, "_int_req"}, 64'(int_req), 64'd1);
    hold_ack = 1'b1;
    int_pc   = pc;
    wait_trap(tag);
    hold_ack = 1'b0;
  endtask

  task automatic finish_redir(input string tag);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_int_req"}, 64'(int_req), 64'd0);
  endtask

  initial begin
    int pm0, ps0;
    rst = 1'b1;
    priv = 4'b0001; mie = 1'b0; sie = 1'b0;
    mip = '0; mie_en = '0; mideleg = '0; medeleg = '0;
    mtvec = '0; stvec = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_tval = '0;
    hold_ack = 1'b0; int_pc = '0; redirect_ready = 1'b0;

    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outs", 64'({int_req, trap_target_m, trap_target_s, redirect_valid}), 64'd0);
    chk("reset_cause", cause, 64'd0);
    chk("reset_rpc", redirect_pc, 64'd0);
    rst = 1'b0;
    tick();

    // M timer interrupt from U, vectored mtvec, ack two cycles after int_req.
    priv = 4'b0001; mip = 12'h080; mie_en = 12'h080; mideleg = '0;
    mtvec = 64'h8000_0001;
    push(1'b0, 64'h8000_0000_0000_0007, 64'h1000, 64'd0, 64'h8000_001C);
    tick();
    chk("mti_int_req", 64'(int_req), 64'd1);
    tick();
    tick();
    chk("mti_no_early_trap", 64'(n_pm + n_ps), 64'd0);
    chk("mti_still_hold", 64'(int_req & busy), 64'd1);
    hold_ack = 1'b1;
    int_pc   = 64'h1000;
    wait_trap("mti");
    hold_ack = 1'b0;
    mip = '0;
    tick();
    chk("mti_int_req_redir", 64'(int_req), 64'd1);
    chk("mti_rpc_stable", redirect_pc, 64'h8000_001C);
    finish_redir("mti");
    chk("mti_rvalid_drop", 64'(redirect_valid), 64'd0);
    chk("mti_single_pulse", 64'(n_pm), 64'd1);

    // Delegated SSI taken at S with SIE, direct stvec.
    priv = 4'b0010; sie = 1'b1; mip = 12'h002; mie_en = 12'h002; mideleg = 12'h002;
    stvec = 64'h2000;
    run_int("ssi", 64'h3000, 1'b1, 4'd1, 64'h2000);
    mip = '0;
    finish_redir("ssi");

    // Same delegated SSI at M: never taken.
    priv = 4'b1000; mie = 1'b1; mip = 12'h002;
    tick();
    tick();
    tick();
    chk("ssi_at_m_int_req", 64'(int_req), 64'd0);
    chk("ssi_at_m_busy", 64'(busy), 64'd0);
    mip = '0; mie = 1'b0; sie = 1'b0; mideleg = '0;

    // Delegated exception beats a pending MEI; MEI follows after IDLE.
    priv = 4'b0001; medeleg = 16'h0004; mie_en = 12'h800; mip = 12'h800;
    exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 64'h400; exc_tval = 64'hDEAD;
    push(1'b1, 64'd2, 64'h400, 64'hDEAD, 64'h2000);
    wait_trap("exc");
    exc_valid = 1'b0;
    pm0 = n_pm;
    finish_redir("exc");
    chk("exc_tval_held", tval, 64'hDEAD);
    chk("exc_no_mei_yet", 64'(n_pm - pm0), 64'd0);
    run_int("mei_after_exc", 64'h404, 1'b0, 4'd11, 64'h8000_002C);
    mip = '0;
    finish_redir("mei_after_exc");

    // MSI withdrawn while holding: back to IDLE, no trap.
    pm0 = n_pm; ps0 = n_ps;
    mie_en = 12'h008; mip = 12'h008;
    tick();
    chk("wd_int_req", 64'(int_req), 64'd1);
    mie_en = '0;
    tick();
    chk("wd_int_req_drop", 64'(int_req), 64'd0);
    chk("wd_busy", 64'(busy), 64'd0);
    hold_ack = 1'b1;
    tick();
    tick();
    hold_ack = 1'b0;
    chk("wd_no_pulse", 64'((n_pm - pm0) + (n_ps - ps0)), 64'd0);
    mip = '0;

    // Priority walk: 11, then 3, then 7.
    mip = 12'hAAA; mie_en = 12'hAAA; mideleg = '0;
    run_int("prio11", 64'h500, 1'b0, 4'd11, 64'h8000_002C);
    mip = 12'h2AA;
    finish_redir("prio11");
    run_int("prio3", 64'h504, 1'b0, 4'd3, 64'h8000_000C);
    mip = 12'h2A2;
    finish_redir("prio3");
    run_int("prio7", 64'h508, 1'b0, 4'd7, 64'h8000_001C);
    mip = '0; mie_en = '0;
    finish_redir("prio7");

    // Exception at M ignores medeleg; reset while redirect_valid is high.
    priv = 4'b1000; medeleg = 16'h0020;
    exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 64'h600; exc_tval = 64'h77;
    push(1'b0, 64'd5, 64'h600, 64'h77, 64'h8000_0000);
    wait_trap("exc_m");
    exc_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rvalid", 64'(redirect_valid), 64'd0);
    chk("rst_rpc", redirect_pc, 64'd0);
    chk("rst_csr", cause | epc | tval, 64'd0);
    chk("rst_ctrl", 64'({int_req, trap_target_m, trap_target_s, busy}), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_idle", 64'(busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap-entry sequencer in the CU/RU csr area.
- Each cycle it arbitrates pending interrupts against a WB-stage synchronous exception, and resolves delegation and the target privilege (M or S).
- Holds the pipeline for interrupts, then issues the one-cycle trap_target_m / trap_target_s pulse that drives the status/priv update.
- Supplies cause/epc/tval and the redirect PC (from mtvec/stvec) to the fetch unit over a valid/ready handshake.

Parameters:
XLEN, 64, data/address width of cause, epc, tval, tvec, pc
EXC_W, 16, number of exception codes covered by medeleg

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
priv  in  4  current privilege, one-hot: 1000 M, 0010 S, 0001 U
mie  in  1  mstatus.MIE
sie  in  1  mstatus.SIE
mip  in  12  pending interrupt bits (spec bit positions)
mie_en  in  12  mie CSR (per-interrupt enables)
mideleg  in  12  interrupt delegation to S
medeleg  in  EXC_W  exception delegation to S
mtvec  in  XLEN  M trap vector, [1:0] = mode
stvec  in  XLEN  S trap vector, [1:0] = mode
exc_valid  in  1  WB-stage instruction raised a synchronous exception
exc_code  in  4  exception code
exc_pc  in  XLEN  PC of the faulting instruction
exc_tval  in  XLEN  trap value
int_req  out  1  request pipeline hold at an instruction boundary
hold_ack  in  1  pipeline drained/held; int_pc is valid
int_pc  in  XLEN  PC of the next unretired instruction
trap_target_m  out  1  one-cycle pulse: take trap into M
trap_target_s  out  1  one-cycle pulse: take trap into S
cause  out  XLEN  mcause/scause write value
epc  out  XLEN  mepc/sepc write value
tval  out  XLEN  mtval/stval write value
redirect_valid  out  1  redirect PC valid
redirect_pc  out  XLEN  trap handler address
redirect_ready  in  1  fetch accepted redirect
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async): state=IDLE; all outputs 0.
  - Reset mid-operation aborts immediately.
  - Pulses and redirect_valid drop in the same cycle rst asserts.
- Interrupt candidate: int_pend = mip & mie_en.
  - Fixed priority order: 11 MEI, 3 MSI, 7 MTI, 9 SEI, 1 SSI, 5 STI.
  - Only the highest-priority pending bit is considered.
- Interrupt target and take rules:
  - Not delegated (mideleg[i]=0): target M. Taken if priv!=M, or priv=M and mie=1.
  - Delegated: target S. Taken if priv=U, or priv=S and sie=1. Never taken at priv=M.
- Exception target: S if medeleg[exc_code]=1 and priv!=M; otherwise M.
  - exc_code >= EXC_W is treated as not delegated.
- FSM states: IDLE, HOLD, TRAP, REDIR.
- IDLE:
  - exc_valid=1: latch code/pc/tval/target, go to TRAP. An exception wins over an interrupt in the same cycle.
  - Else, a takeable interrupt exists: latch code and target, go to HOLD.
- HOLD:
  - int_req=1.
  - exc_valid=1: latch the exception instead, go to TRAP.
  - Else, the latched interrupt is no longer takeable (pending or enable dropped): go to IDLE, int_req=0, no trap.
  - Else, hold_ack=1: latch int_pc, go to TRAP.
  - int_req stays 1 through TRAP and REDIR, and drops on return to IDLE.
- TRAP (exactly one cycle):
  - trap_target_m or trap_target_s = 1, matching the latched target; never both.
  - cause, epc and tval are valid this cycle.
  - For interrupts: cause = {1, zeros, 4-bit code}, epc = int_pc, tval = 0.
  - For exceptions: cause = {0, zeros, exc_code}, epc = exc_pc, tval = exc_tval.
  - cause/epc/tval hold their value until the next TRAP.
  - Next state: REDIR.
- redirect_pc, computed in TRAP and registered:
  - base = {tvec[XLEN-1:2], 2'b00}, using mtvec or stvec per the target.
  - Interrupt with tvec[1:0]=01: base + 4*code. Otherwise base.
  - Add is modulo 2^XLEN.
- REDIR:
  - redirect_valid=1; redirect_pc is stable until accepted.
  - On redirect_ready=1: go to IDLE.
  - exc_valid and mip are ignored while in TRAP/REDIR.
- Latency:
  - Exception: exc_valid in IDLE, trap pulse the next cycle, redirect_valid the cycle after.
  - Interrupt: the trap pulse comes 1 cycle after hold_ack is sampled.
- busy = (state != IDLE).

Test Plan:
- Reset mid-REDIR: assert rst while redirect_valid=1 -> all outputs 0 in the same cycle; state IDLE after release.
- M timer interrupt: priv=0001, mip=mie_en=0x080, mideleg=0, mtvec=0x8000_0001, hold_ack high 2 cycles after int_req, int_pc=0x1000 -> single trap_target_m pulse; cause=0x8000_0000_0000_0007; epc=0x1000; tval=0; redirect_pc=0x8000_001C; int_req held until redirect_ready.
- Delegated SSI: priv=0010, sie=1, mip=mie_en=0x002, mideleg=0x002, stvec=0x2000 -> trap_target_s; cause=0x8000_0000_0000_0001; redirect_pc=0x2000. Same stimulus with priv=1000 -> no int_req.
- Exception vs interrupt: exc_valid with exc_code=2, exc_pc=0x400, exc_tval=0xDEAD, medeleg=0x0004, priv=0001, and MEI pending in the same cycle -> trap_target_s; cause=2; epc=0x400; tval=0xDEAD. The interrupt is taken only after return to IDLE.
- Interrupt withdrawn: enter HOLD on MSI, clear mie_en[3] before hold_ack -> return to IDLE, int_req=0, no trap pulse.
- Priority: mip=mie_en=0xAAA, priv=0001, mideleg=0 -> cause code 11. Then clear bit 11 -> code 3. Then clear bit 3 -> code 7.
